// File: rtl/queue_seq_pkg.sv
// Shared state encoding and defaults for the queue sequencer.
package queue_seq_pkg;

    localparam int FRAME_LEN_DEF = 784;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/queue_seq_if.sv
// Handshake and storage strobes between the sequencer (master) and its surroundings (slave).
interface queue_seq_if;
    logic in_vld;
    logic in_rdy;
    logic out_rdy;
    logic q_push;
    logic q_pop;
    logic out_vld;

    modport master (input in_vld, out_rdy, output in_rdy, q_push, q_pop, out_vld);
    modport slave  (output in_vld, out_rdy, input in_rdy, q_push, q_pop, out_vld);
endinterface

// File: rtl/queue_seq_frame_cnt.sv
// Saturating per-frame push/pop counters with terminal and one-before-terminal flags.
module qs_frame_cnt
    import queue_seq_pkg::*;
#(
    parameter int LIMIT = FRAME_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_inc,
    input  logic out_inc,
    output logic in_term,
    output logic in_last,
    output logic out_term
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] in_cnt;
    logic [W-1:0] out_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (clr) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (in_inc && !in_term)   in_cnt  <= in_cnt + 1'b1;
            if (out_inc && !out_term) out_cnt <= out_cnt + 1'b1;
        end
    end

    assign in_term  = (in_cnt == W'(LIMIT));
    assign in_last  = (in_cnt == W'(LIMIT - 1));
    assign out_term = (out_cnt == W'(LIMIT));

endmodule

// File: rtl/queue_seq.sv
// Frame sequencer driving an external queue storage. Optional macro QUEUE_SEQ_ERR_EN
// adds a sticky err output for start requests arriving outside IDLE.
module queue_seq
    import queue_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       start,
    queue_seq_if.master                qif,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done
`ifdef QUEUE_SEQ_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);

    if (WIDTH < 1 || DEPTH < 1) begin : g_bad_cfg
        $error("queue_seq: WIDTH and DEPTH must be at least 1");
    end

    state_t state, state_nxt;
    logic   push, pop, clr, run_ph;
    logic   in_term, in_last, out_term;
    logic   rd_vld;

    assign run_ph = (state == FILL) || (state == RUN);
    assign clr    = ce && start && (state == IDLE);
    assign pop    = ce && qif.out_rdy && (count != '0) && ((state == RUN) || (state == DRAIN));
    // A same-cycle pop frees a slot, so a full queue still accepts in RUN.
    assign qif.in_rdy = ce && run_ph && !in_term && ((count < FULL) || pop);
    assign push       = qif.in_vld && qif.in_rdy;

    assign qif.q_push = push;
    assign qif.q_pop  = pop;

    qs_frame_cnt #(.LIMIT(FRAME_LEN)) u_frame_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_inc   (push),
        .out_inc  (pop),
        .in_term  (in_term),
        .in_last  (in_last),
        .out_term (out_term)
    );

    always_ff @(posedge clk) begin
        if (!rst)                count <= '0;
        else if (clr)            count <= '0;
        else if (push && !pop)   count <= count + 1'b1;
        else if (pop && !push)   count <= count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (ce && start) state_nxt = FILL;
            FILL: begin
                if (push && in_last)                state_nxt = DRAIN;
                else if (push && (count == FULL_M1)) state_nxt = RUN;
            end
            RUN:   if (push && in_last) state_nxt = DRAIN;
            DRAIN: if (ce && (count == '0) && out_term) state_nxt = DONE;
            DONE:  if (ce) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frozen with ce so a read issued just before a stall is still reported after it.
    always_ff @(posedge clk) begin
        if (!rst)    rd_vld <= 1'b0;
        else if (ce) rd_vld <= pop;
    end

    assign qif.out_vld = rd_vld && ce;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE) && ce;

`ifdef QUEUE_SEQ_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst)                                err <= 1'b0;
        else if (ce && start && state != IDLE)   err <= 1'b1;
    end
`endif

endmodule

// File: doc/queue_seq.md
QUEUE_SEQ -- requirements
Module: queue_seq

Interface
REQ-001 Parameter WIDTH, default 8, data width of the controlled queue storage.
REQ-002 Parameter DEPTH, default 3, queue storage entries.
REQ-003 Parameter FRAME_LEN, default 784, pixels per frame.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 ce  input  1  clock enable; low freezes all state.
REQ-007 start  input  1  begin one frame; honoured only in IDLE.
REQ-008 in_vld  input  1  upstream pixel valid.
REQ-009 in_rdy  output  1  upstream ready.
REQ-010 out_rdy  input  1  downstream ready to consume.
REQ-011 q_push  output  1  push strobe to queue storage.
REQ-012 q_pop  output  1  read strobe to queue storage.
REQ-013 out_vld  output  1  queue data output valid.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse at frame completion.

Function
REQ-017 FSM states shall be IDLE, FILL, RUN, DRAIN and DONE.
REQ-018 IDLE->FILL on start&ce; clears in_cnt, out_cnt and count.
REQ-019 FILL->RUN in the cycle a push makes count==DEPTH.
REQ-020 FILL or RUN->DRAIN in the cycle the push makes in_cnt==FRAME_LEN (takes priority over FILL->RUN).
REQ-021 DRAIN->DONE when count==0 and out_cnt==FRAME_LEN; DONE->IDLE next cycle with done=1 for that single cycle.
REQ-022 in_rdy = ce & state in {FILL,RUN} & in_cnt<FRAME_LEN & (count<DEPTH | q_pop).
REQ-023 q_push = in_vld & in_rdy; combinational; increments in_cnt.
REQ-024 q_pop = ce & out_rdy & count>0 & state in {RUN,DRAIN}; combinational; increments out_cnt.
REQ-025 out_vld shall be q_pop registered by one cycle, matching the one-cycle read latency of the storage; forced to 0 when ce is low.
REQ-026 count: push only +1, pop only -1, both or neither unchanged; it shall never exceed DEPTH or underflow.
REQ-027 Simultaneous push and pop at count==DEPTH is legal in RUN and keeps count at DEPTH.
REQ-028 start outside IDLE is ignored.
REQ-029 ce low: q_push=q_pop=0, in_rdy=0; state and all counters hold.
REQ-030 in_cnt and out_cnt shall be $clog2(FRAME_LEN+1) bits wide and never wrap.

Reset
REQ-031 rst low shall force state=IDLE, count=0, in_cnt=out_cnt=0, out_vld=0, done=0 and busy=0 in the next cycle, including mid-frame; the partial frame is discarded.

Configuration
REQ-032 Macro QUEUE_SEQ_ERR_EN defined: the block adds output port err (1 bit), set sticky when start&ce is asserted outside IDLE and cleared only by reset.
REQ-033 Macro QUEUE_SEQ_ERR_EN undefined: no err port and no error logic; a start outside IDLE is silently ignored.

Structure
REQ-034 Package queue_seq_pkg shall hold the state encoding constants (IDLE=0, FILL=1, RUN=2, DRAIN=3, DONE=4, 3 bits) and the FRAME_LEN default.
REQ-035 One sub-module, qs_frame_cnt, shall implement the saturating in_cnt and out_cnt counter with its terminal flag; the queue storage is instanced by the parent, not inside this block.

Verification (DEPTH=3, FRAME_LEN=5)
REQ-036 start, in_vld held high, out_rdy=0 -> 3 pushes in 3 cycles, count=3, state RUN, in_rdy=0.
REQ-037 Next, out_rdy=1, in_vld=1 -> push+pop each cycle, count stays 3; after in_cnt=5 -> DRAIN, pops until count=0; out_vld 1 cycle after each q_pop; 5 out_vld total; done pulse once.
REQ-038 ce=0 for 4 cycles mid-RUN -> no strobes, out_vld=0, count/state unchanged; resumes identically.
REQ-039 rst=0 in DRAIN with count=2 -> next cycle IDLE, count=0, busy=0, no done.
REQ-040 start pulsed in RUN with QUEUE_SEQ_ERR_EN -> err=1 and held; frame unaffected; without the macro, identical frame and no err port.
